// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready.
// Optional saturation on signed overflow: define ADDSUB_SAT_EN.
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int L = WIDTH / 2;

    // Half-width adder built from GRP-wide lookahead groups; returns {cout, sum}.
    function automatic logic [L:0] cla_add(
        input logic [L-1:0] a,
        input logic [L-1:0] b,
        input logic         cin
    );
        logic [L-1:0] g;
        logic [L-1:0] p;
        logic [L:0]   c;
        logic         gg;
        logic         gp;
        logic         cg;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < L / GRP; k++) begin
            cg = c[k*GRP];
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < GRP; j++) begin
                gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
                gp = gp & p[k*GRP+j];
                c[k*GRP+j+1] = gg | (gp & cg);
            end
        end
        return {c[L], p ^ c[L-1:0]};
    endfunction

    logic         s1_valid;
    logic [L-1:0] s1_slo;
    logic         s1_clo;
    logic [L-1:0] s1_ahi;
    logic [L-1:0] s1_bhi;

    logic             adv2;
    logic             accept;
    logic [WIDTH-1:0] bx;
    logic [L:0]       lo_res;
    logic [L:0]       hi_res;
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] sum_f;
    logic             ovf_w;

    assign adv2     = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | adv2;
    assign accept   = in_valid & in_ready;

    // Stage 1 operand conditioning and low-half add.
    always_comb begin
        bx     = in_sub ? ~in_b : in_b;
        lo_res = cla_add(in_a[L-1:0], bx[L-1:0], in_sub);
    end

    // Stage 2 high-half add, flags and optional saturation.
    always_comb begin
        hi_res = cla_add(s1_ahi, s1_bhi, s1_clo);
        sum_w  = {hi_res[L-1:0], s1_slo};
        ovf_w  = (s1_ahi[L-1] == s1_bhi[L-1]) &
                 (hi_res[L-1] != s1_ahi[L-1]);
`ifdef ADDSUB_SAT_EN
        if (ovf_w)
            sum_f = s1_ahi[L-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sum_f = sum_w;
`else
        sum_f = sum_w;
`endif
    end

    // Stage 1 register: loads on accept, empties when drained into stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_slo   <= '0;
            s1_clo   <= 1'b0;
            s1_ahi   <= '0;
            s1_bhi   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_slo <= lo_res[L-1:0];
                s1_clo <= lo_res[L];
                s1_ahi <= in_a[WIDTH-1:L];
                s1_bhi <= bx[WIDTH-1:L];
            end
        end
    end

    // Output register: advances when empty or consumed, holds on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_f;
                out_cout <= hi_res[L];
                out_ovf  <= ovf_w;
                out_zero <= (sum_f == '0);
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Randomized self-checking bench for cla_addsub_pipe.
// Expected results come from a signed/unsigned arithmetic model and a queue.
module tb_cla_addsub_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_rdy = 0;

    logic [W+2:0] q[$];

    cla_addsub_pipe #(.WIDTH(W), .GRP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Result as {zero, ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic sub);
        longint       sa;
        longint       sb;
        longint       r;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (sub) begin
            s    = a - b;
            cout = (a >= b);
        end else begin
            s    = a + b;
            cout = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF;
        end
`ifdef ADDSUB_SAT_EN
        if (ovf) s = (r > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        return {(s == '0), ovf, cout, s};
    endfunction

    // Scoreboard: record accepted beats, compare delivered beats in order.
    always @(negedge clk) begin
        logic [W+2:0] e;
        if (!rst) begin
            if (in_valid && in_ready)
                q.push_back(model(in_a, in_b, in_sub));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", {29'd0, out_zero, out_ovf, out_cout, out_sum},
                        {29'd0, e});
                end
            end
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h7FFFFFFF;
            1: v = 32'h80000000;
            2: v = 32'hFFFFFFFF;
            3: v = 32'h0000FFFF;
            4: v = 32'h0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_flags", {29'd0, out_zero, out_ovf, out_cout, out_sum}, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        send(32'd5, 32'd3, 1'b0);
        in_valid = 1'b0;
        chk("lat_edge1", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", {63'd0, out_valid}, 64'd1);
        idle(2);

        send(32'd5, 32'd5, 1'b1);
        idle(3);
        send(32'd3, 32'd5, 1'b1);
        idle(3);
        send(32'h7FFFFFFF, 32'd1, 1'b0);
        idle(3);
        send(32'h0000FFFF, 32'd1, 1'b0);
        idle(3);
        send(32'hFFFFFFFF, 32'd1, 1'b0);
        idle(3);
        send(32'h80000000, 32'd1, 1'b1);
        idle(3);

        send(32'd100, 32'd1, 1'b0);
        send(32'd200, 32'd2, 1'b1);
        out_ready = 1'b0;
        fork
            begin
                @(negedge clk);
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(32'd300, 32'd3, 1'b0);
        send(32'd400, 32'd4, 1'b1);
        idle(4);

        send(32'd11, 32'd22, 1'b0);
        send(32'd33, 32'd44, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_out_sum", {32'd0, out_sum}, 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        send(32'd1000, 32'd234, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_lat", {63'd0, out_valid}, 64'd1);
        idle(2);

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        in_valid = 1'b0;
        rand_rdy = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
